// File: rtl/lvds_tx_arbiter.sv
// Round-robin arbiter that pops one word from a granted source, tags it with
// {1, id, payload} and offers it to the LVDS TX enq port.
module lvds_tx_arbiter #(
  parameter  int ID_W      = 2,
  parameter  int CNT_W     = 16,
  localparam int NUM_REQ   = 2**ID_W,
  localparam int PAYLOAD_W = 31 - ID_W
) (
  input  logic                           tx_inclock,
  input  logic                           reset_n,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             RDY_req,
  output logic [NUM_REQ-1:0]             EN_req,
  input  logic [NUM_REQ-1:0]             chan_enable,
  input  logic                           link_up,
  output logic [31:0]                    enq_tx,
  output logic                           RDY_enq_tx,
  input  logic                           EN_enq_tx,
  output logic [ID_W-1:0]                grant_id,
  output logic [CNT_W-1:0]               frame_count
);

  // state   | meaning
  // S_IDLE  | no word held; grant the next eligible channel after the pointer
  // S_OFFER | tagged word held and offered to the link until consumed
  typedef enum logic {S_IDLE, S_OFFER} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic [31:0]        hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [ID_W-1:0]    pick;
  logic [ID_W-1:0]    cand;
  logic               accept;

  always_ff @(posedge tx_inclock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      gid_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Search starts one past the last grant; offset NUM_REQ wraps back to the pointer itself.
  always_comb begin
    eligible = RDY_req & chan_enable & {NUM_REQ{link_up}};
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ptr_q + ID_W'(i);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    hold_d     = hold_q;
    cnt_d      = cnt_q;
    EN_req     = '0;
    RDY_enq_tx = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found && reset_n) begin
          EN_req[pick] = 1'b1;
          hold_d       = {1'b1, pick, req_data[pick*PAYLOAD_W +: PAYLOAD_W]};
          gid_d        = pick;
          ptr_d        = pick;
          state_d      = S_OFFER;
        end
      end
      S_OFFER: begin
        RDY_enq_tx = link_up & reset_n;
        accept     = EN_enq_tx & link_up & reset_n;
        if (accept) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enq_tx      = (state_q == S_OFFER && reset_n) ? hold_q : 32'h0;
  assign grant_id    = gid_q;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_lvds_tx_arbiter.sv
// Self-checking bench for lvds_tx_arbiter against a transaction-level round-robin model.
module tb_lvds_tx_arbiter;
  localparam int ID_W = 2;
  localparam int NR   = 4;
  localparam int PW   = 29;
  localparam int CW   = 10;
  localparam int CMAX = 2**CW - 1;

  logic             clk;
  logic             rst_n;
  logic [NR*PW-1:0] req_data;
  logic [NR-1:0]    rdy_req, en_req, chan_en;
  logic             link_up, en_enq, rdy_enq;
  logic [31:0]      enq_tx;
  logic [ID_W-1:0]  grant_id;
  logic [CW-1:0]    frame_count;

  int checks = 0;
  int errors = 0;

  // reference model
  bit          m_held;
  logic [31:0] m_word;
  int          m_ptr, m_gid, m_cnt;
  int          e_k;
  logic [NR-1:0] e_en;
  logic        e_rdy;
  logic [31:0] e_enq;

  lvds_tx_arbiter #(.ID_W(ID_W), .CNT_W(CW)) dut (
    .tx_inclock (clk),
    .reset_n    (rst_n),
    .req_data   (req_data),
    .RDY_req    (rdy_req),
    .EN_req     (en_req),
    .chan_enable(chan_en),
    .link_up    (link_up),
    .enq_tx     (enq_tx),
    .RDY_enq_tx (rdy_enq),
    .EN_enq_tx  (en_enq),
    .grant_id   (grant_id),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compute_exp();
    e_en  = '0;
    e_rdy = 1'b0;
    e_enq = 32'h0;
    e_k   = -1;
    if (rst_n) begin
      if (m_held) begin
        e_rdy = link_up;
        e_enq = m_word;
      end else if (link_up) begin
        for (int i = 1; i <= NR; i++) begin
          int k;
          k = (m_ptr + i) % NR;
          if (e_k < 0 && rdy_req[k] && chan_en[k]) e_k = k;
        end
        if (e_k >= 0) e_en[e_k] = 1'b1;
      end
    end
  endtask

  task automatic advance();
    logic [ID_W-1:0] kk;
    compute_exp();
    if (!rst_n) begin
      m_held = 0; m_ptr = NR - 1; m_gid = 0; m_cnt = 0;
    end else if (m_held) begin
      if (en_enq && link_up) begin
        m_cnt  = (m_cnt + 1) % (CMAX + 1);
        m_held = 0;
      end
    end else if (e_k >= 0) begin
      kk     = e_k[ID_W-1:0];
      m_word = {1'b1, kk, req_data[e_k*PW +: PW]};
      m_held = 1;
      m_ptr  = e_k;
      m_gid  = e_k;
    end
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int k = 0; k < NR; k++) req_data[k*PW +: PW] = PW'($urandom);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy_req = '1; chan_en = '1; link_up = 1'b1; en_enq = 1'b0;
    rand_data();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (en_req !== 4'b0 || rdy_enq !== 1'b0 || enq_tx !== 32'h0 ||
          frame_count !== '0 || grant_id !== 2'd0) begin
        errors++;
        $display("FAIL reset: en_req=%b rdy=%b enq=%h cnt=%h gid=%0d expected all 0",
                 en_req, rdy_enq, enq_tx, frame_count, grant_id);
      end
      advance();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    rdy_req = 4'b0100; chan_en = '1; link_up = 1'b1; en_enq = 1'b0;
    rand_data();
    req_data[2*PW +: PW] = 29'h0ABCDEF;
    #1;
    checks++;
    if (en_req !== 4'b0100) begin
      errors++; $display("FAIL single_pop: en_req=%b expected 0100", en_req);
    end
    advance();
    rdy_req = 4'b0000;
    #1;
    checks++;
    if (rdy_enq !== 1'b1 || enq_tx !== 32'hC0ABCDEF || en_req !== 4'b0) begin
      errors++;
      $display("FAIL single_offer: rdy=%b enq=%h en_req=%b expected 1 C0ABCDEF 0000",
               rdy_enq, enq_tx, en_req);
    end
    en_enq = 1'b1;
    advance();
    en_enq = 1'b0;
    #1;
    checks++;
    if (frame_count !== CW'(1) || rdy_enq !== 1'b0 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_count: cnt=%0d rdy=%b gid=%0d expected 1 0 2",
               frame_count, rdy_enq, grant_id);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[6];
    int n;
    exp_order = '{0, 1, 2, 3, 0, 1};
    n = 0;
    pulse_reset();
    rdy_req = '1; chan_en = '1; link_up = 1'b1; en_enq = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      #1;
      compute_exp();
      if (m_held) begin
        checks++;
        if (enq_tx !== e_enq || enq_tx[30:29] !== 2'(m_gid)) begin
          errors++;
          $display("FAIL rr_word: enq=%h expected %h", enq_tx, e_enq);
        end
      end else if (n < 6) begin
        checks++;
        if (e_k != exp_order[n] || en_req !== e_en) begin
          errors++;
          $display("FAIL rr_grant%0d: en_req=%b expected channel %0d", n, en_req, exp_order[n]);
        end
        n++;
      end
      advance();
    end
    #1;
    checks++;
    if (n != 6 || frame_count !== CW'(m_cnt)) begin
      errors++;
      $display("FAIL rr_total: grants=%0d cnt=%0d expected 6 %0d", n, frame_count, m_cnt);
    end
  endtask

  task automatic test_mask();
    int exp_order[4];
    int n;
    exp_order = '{0, 2, 3, 0};
    n = 0;
    pulse_reset();
    rdy_req = '1; chan_en = 4'b1101; link_up = 1'b1; en_enq = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rand_data();
      #1;
      compute_exp();
      checks++;
      if (en_req[1] !== 1'b0 || en_req !== e_en) begin
        errors++;
        $display("FAIL mask_en: en_req=%b expected %b", en_req, e_en);
      end
      if (e_k >= 0 && n < 4) begin
        checks++;
        if (e_k != exp_order[n]) begin
          errors++;
          $display("FAIL mask_order%0d: got channel %0d expected %0d", n, e_k, exp_order[n]);
        end
        n++;
      end
      advance();
    end
  endtask

  task automatic test_link_drop();
    logic [31:0] w;
    int cnt0;
    rdy_req = 4'b0010; chan_en = '1; link_up = 1'b1; en_enq = 1'b0;
    rand_data();
    advance();
    w = m_word;
    cnt0 = m_cnt;
    rdy_req = '1; link_up = 1'b0;
    for (int c = 0; c < 10; c++) begin
      en_enq = 1'($urandom_range(0, 1));
      rand_data();
      chan_en = (c == 5) ? 4'b0000 : 4'b1111;
      #1;
      checks++;
      if (rdy_enq !== 1'b0 || en_req !== 4'b0 || enq_tx !== w || frame_count !== CW'(cnt0)) begin
        errors++;
        $display("FAIL link_down: rdy=%b en_req=%b enq=%h cnt=%0d expected 0 0000 %h %0d",
                 rdy_enq, en_req, enq_tx, frame_count, w, cnt0);
      end
      advance();
    end
    link_up = 1'b1; en_enq = 1'b0; chan_en = '1;
    #1;
    checks++;
    if (rdy_enq !== 1'b1 || enq_tx !== w || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL link_reoffer: rdy=%b enq=%h gid=%0d expected 1 %h 1", rdy_enq, enq_tx, grant_id, w);
    end
    en_enq = 1'b1;
    advance();
    en_enq = 1'b0;
    #1;
    checks++;
    if (frame_count !== CW'(cnt0 + 1)) begin
      errors++;
      $display("FAIL link_accept: cnt=%0d expected %0d", frame_count, cnt0 + 1);
    end
  endtask

  task automatic test_wrap();
    rdy_req = '1; chan_en = '1; link_up = 1'b1; en_enq = 1'b1;
    for (int c = 0; c < 4 * (CMAX + 1) && !(m_cnt == CMAX && !m_held); c++) advance();
    #1;
    checks++;
    if (frame_count !== CW'(CMAX)) begin
      errors++; $display("FAIL wrap_max: cnt=%h expected %h", frame_count, CMAX);
    end
    for (int c = 0; c < 4 && m_cnt != 0; c++) advance();
    #1;
    checks++;
    if (frame_count !== '0) begin
      errors++; $display("FAIL wrap_zero: cnt=%h expected 0", frame_count);
    end
    en_enq = 1'b0;
    advance();
    #1;
    checks++;
    if (rdy_enq !== 1'b1) begin
      errors++; $display("FAIL wrap_offer: rdy=%b expected 1", rdy_enq);
    end
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
    rdy_req = '0;
    #1;
    checks++;
    if (rdy_enq !== 1'b0 || enq_tx !== 32'h0 || en_req !== 4'b0 || frame_count !== '0) begin
      errors++;
      $display("FAIL reset_in_offer: rdy=%b enq=%h en_req=%b cnt=%0d expected all 0",
               rdy_enq, enq_tx, en_req, frame_count);
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      rdy_req = 4'($urandom);
      chan_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      link_up = ($urandom_range(0, 5) != 0);
      en_enq  = 1'($urandom_range(0, 1));
      rand_data();
      #1;
      compute_exp();
      checks++;
      if (en_req !== e_en || rdy_enq !== e_rdy || enq_tx !== e_enq ||
          frame_count !== CW'(m_cnt) || grant_id !== 2'(m_gid)) begin
        errors++;
        $display("FAIL random_c%0d: en_req=%b/%b rdy=%b/%b enq=%h/%h cnt=%0d/%0d gid=%0d/%0d",
                 c, en_req, e_en, rdy_enq, e_rdy, enq_tx, e_enq, frame_count, m_cnt, grant_id, m_gid);
      end
      advance();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rdy_req = '1; chan_en = '1; link_up = 1'b0; en_enq = 1'b0;
    req_data = '0;
    m_held = 0; m_word = '0; m_ptr = NR - 1; m_gid = 0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_link_drop();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
